// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, RAM handshake state, memory-controller FSM state
// and memory operation kind.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // RAM model handshake state
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // memory_control FSM state
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    INSTR = 3'd2,
    RETRY = 3'd3,
    RESP  = 3'd4
  } memctl_state_t;

  // Kind of transaction latched by memory_control
  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } memop_t;

endpackage

// File: rtl/memory_control_if.sv
// Memory controller signal bundle.
//   mc : controller view (requests/RAM status in, hits/RAM control out)
//   tb : requester + RAM view (mirror of mc)
interface memory_control_if;
  import cpu_types_pkg::*;

  logic  iREN, dREN, dWEN;
  word_t iaddr, daddr, dstore;
  logic  ihit, dhit;
  word_t iload, dload;
  logic  ramREN, ramWEN;
  word_t ramaddr, ramstore, ramload;
  logic  [1:0] ramstate;
  logic  memerr;

  modport mc (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Saturating RAM wait watchdog.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the count (transaction enters a RAM phase)
//   count      : one more cycle spent waiting on the RAM
//   expire_c   : this counted cycle brings the count to MAX_WAIT (or beyond)
module mem_wait_counter #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expire_c
);

  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  // Count waiting cycles, holding at MAX_WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && (cnt != CW'(MAX_WAIT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Flag the cycle whose increment reaches the limit, so the sticky error
  // is visible right after MAX_WAIT wait cycles.
  assign expire_c = count && (cnt >= CW'(MAX_WAIT - 1));

endmodule

// File: rtl/memory_control.sv
// Memory controller: arbitrates instruction fetches and data loads/stores
// onto a single-ported variable-latency RAM and returns one-cycle hits.
//   CLK, nRST                   : clock, async active-low reset
//   iREN, iaddr                 : fetch request (held until ihit)
//   dREN, dWEN, daddr, dstore   : data request (held until dhit)
//   ihit, iload / dhit, dload   : completion pulses with returned word
//   ramREN, ramWEN, ramaddr,
//   ramstore                    : RAM control (registered)
//   ramload, ramstate           : RAM response
//   memerr                      : sticky watchdog error
module memory_control
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  memctl_state_t state, nstate;
  memop_t        op_q, op_d;
  word_t         addr_d, store_d;
  ramstate_t     rs;
  logic          ren_d, wen_d, ihit_d, dhit_d;
  logic          in_ram, next_in_ram, enter_ram, capture;
  logic          expire_c;

  assign rs          = ramstate_t'(ramstate);
  assign in_ram      = (state == DATA) || (state == INSTR);
  assign next_in_ram = (nstate == DATA) || (nstate == INSTR);
  assign enter_ram   = next_in_ram && !in_ram;
  assign capture     = in_ram && (rs == ACCESS);

  // Next state, request latch and next registered outputs
  always_comb begin
    nstate  = state;
    op_d    = op_q;
    addr_d  = ramaddr;
    store_d = ramstore;
    case (state)
      IDLE: begin
        // data wins over a simultaneous fetch
        if (dREN || dWEN) begin
          nstate  = DATA;
          op_d    = dWEN ? OP_STORE : OP_LOAD;
          addr_d  = daddr;
          store_d = dstore;
        end else if (iREN) begin
          nstate = INSTR;
          op_d   = OP_FETCH;
          addr_d = iaddr;
        end
      end
      DATA, INSTR: begin
        if (rs == ACCESS)     nstate = RESP;
        else if (rs == ERROR) nstate = RETRY;
      end
      RETRY:   nstate = (op_q == OP_FETCH) ? INSTR : DATA;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase

    ren_d  = ((nstate == DATA) && (op_d == OP_LOAD)) || (nstate == INSTR);
    wen_d  = (nstate == DATA) && (op_d == OP_STORE);
    ihit_d = (nstate == RESP) && (op_d == OP_FETCH);
    dhit_d = (nstate == RESP) && (op_d != OP_FETCH);
  end

  // State, latches and registered outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      op_q     <= OP_FETCH;
      ramaddr  <= '0;
      ramstore <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      memerr   <= 1'b0;
    end else begin
      state    <= nstate;
      op_q     <= op_d;
      ramaddr  <= addr_d;
      ramstore <= store_d;
      ramREN   <= ren_d;
      ramWEN   <= wen_d;
      ihit     <= ihit_d;
      dhit     <= dhit_d;
      if (capture && (op_q == OP_FETCH)) iload <= ramload;
      if (capture && (op_q == OP_LOAD))  dload <= ramload;
      if (expire_c)                      memerr <= 1'b1;
    end
  end

  mem_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk      (CLK),
    .rst_n    (nRST),
    .clear    (enter_ram),
    .count    (in_ram),
    .expire_c (expire_c)
  );

endmodule

// File: tb/tb_memory_control.sv
// Self-checking bench for memory_control: the bench plays both requester
// and RAM, and predicts every cycle from a per-transaction RAM schedule.
module tb_memory_control;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic        ihit, dhit, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = 2'd0;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model of architecturally visible registers
  word_t m_iload  = '0;
  word_t m_dload  = '0;
  bit    m_memerr = 1'b0;

  always #5 CLK = ~CLK;

  memory_control #(.MAX_WAIT(255)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  // Drives one transaction from an IDLE cycle (cycle 0) to its hit cycle.
  // RAM answers follow 'sched': nbusy BUSY cycles, an ERROR inserted before
  // BUSY number err_pos (-1: none), then ACCESS. A cycle after ERROR is the
  // retry cycle with enables expected low. Returns number of bad cycles,
  // whether the hit cycle looked right, and whether the returned word matched.
  task automatic run_txn(input memop_t op, input word_t addr, input word_t wdata,
                         input word_t rdata, input int nbusy, input int err_pos,
                         input bit drop, input bit hold_i, input word_t hold_iaddr,
                         output int bad, output bit hit_ok, output bit data_ok);
    ramstate_t sched[$];
    bit en, want_r, want_w;
    for (int k = 0; k <= nbusy; k++) begin
      if (k == err_pos) begin
        sched.push_back(ERROR);
        sched.push_back(FREE);
      end
      if (k < nbusy) sched.push_back(BUSY);
    end
    sched.push_back(ACCESS);
    bad = 0;

    @(negedge CLK);
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ihit !== 1'b0 || dhit !== 1'b0) bad++;
    iREN     = (op == OP_FETCH) || hold_i;
    iaddr    = (op == OP_FETCH) ? addr : (hold_i ? hold_iaddr : word_t'($urandom));
    dREN     = (op == OP_LOAD);
    dWEN     = (op == OP_STORE);
    daddr    = (op != OP_FETCH) ? addr : word_t'($urandom);
    dstore   = (op == OP_STORE) ? wdata : word_t'($urandom);
    ramstate = FREE;
    ramload  = $urandom;

    for (int c = 1; c <= sched.size(); c++) begin
      @(negedge CLK);
      en     = !(c >= 2 && sched[c-2] == ERROR);
      want_r = en && (op != OP_STORE);
      want_w = en && (op == OP_STORE);
      if (ramREN !== want_r || ramWEN !== want_w) bad++;
      if (ihit !== 1'b0 || dhit !== 1'b0) bad++;
      if (memerr !== m_memerr) bad++;
      if (en && ramaddr !== addr) bad++;
      if (want_w && ramstore !== wdata) bad++;
      if (drop && c == 1) begin
        iREN   = hold_i;
        dREN   = 1'b0;
        dWEN   = 1'b0;
        iaddr  = ~addr;
        daddr  = ~addr;
        dstore = ~wdata;
      end
      ramstate = sched[c-1];
      ramload  = (sched[c-1] == ACCESS) ? rdata : word_t'($urandom);
    end

    @(negedge CLK);
    hit_ok = (ihit === (op == OP_FETCH)) && (dhit === (op != OP_FETCH)) &&
             (ramREN === 1'b0) && (ramWEN === 1'b0);
    if (op == OP_FETCH)     m_iload = rdata;
    else if (op == OP_LOAD) m_dload = rdata;
    data_ok  = (op == OP_FETCH) ? (iload === m_iload) : (dload === m_dload);
    iREN     = hold_i;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    ramstate = FREE;
    ramload  = $urandom;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({ihit, dhit, ramREN, ramWEN, memerr} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 00000", {ihit, dhit, ramREN, ramWEN, memerr});
    end
    n_cmp++;
    if (iload !== 32'h0 || dload !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_loads: got iload=%h dload=%h expected 0", iload, dload);
    end
    n_cmp++;
    if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_ram: got addr=%h store=%h expected 0", ramaddr, ramstore);
    end
    nRST = 1'b1;
  endtask

  task automatic test_fetch();
    int bad; bit hok, dok;
    run_txn(OP_FETCH, 32'h40, 32'h0, 32'h8C220004, 2, -1, 1'b0, 1'b0, 32'h0, bad, hok, dok);
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL fetch_bus: got %0d bad cycles expected 0", bad); end
    n_cmp++;
    if (!hok) begin n_bad++; $display("FAIL fetch_hit: got ihit=%b dhit=%b expected 1/0", ihit, dhit); end
    n_cmp++;
    if (iload !== 32'h8C220004) begin
      n_bad++; $display("FAIL fetch_data: got %h expected 8c220004", iload);
    end
  endtask

  task automatic test_priority();
    int bad; bit hok, dok;
    run_txn(OP_STORE, 32'h100, 32'hDEADBEEF, $urandom, 1, -1, 1'b0, 1'b1, 32'h44, bad, hok, dok);
    n_cmp++;
    if (bad !== 0 || !hok) begin
      n_bad++; $display("FAIL prio_store: got bad=%0d hit_ok=%b expected 0/1", bad, hok);
    end
    n_cmp++;
    if (!dok) begin n_bad++; $display("FAIL prio_store_dload: got %h expected %h", dload, m_dload); end
    run_txn(OP_FETCH, 32'h44, 32'h0, $urandom, 1, -1, 1'b0, 1'b0, 32'h0, bad, hok, dok);
    n_cmp++;
    if (bad !== 0 || !hok || !dok) begin
      n_bad++; $display("FAIL prio_fetch: got bad=%0d hit_ok=%b data_ok=%b expected 0/1/1", bad, hok, dok);
    end
  endtask

  task automatic test_retry();
    int bad; bit hok, dok;
    run_txn(OP_LOAD, 32'h200, 32'h0, 32'h12345678, 0, 0, 1'b0, 1'b0, 32'h0, bad, hok, dok);
    n_cmp++;
    if (bad !== 0 || !hok) begin
      n_bad++; $display("FAIL retry_seq: got bad=%0d hit_ok=%b expected 0/1", bad, hok);
    end
    n_cmp++;
    if (dload !== 32'h12345678) begin
      n_bad++; $display("FAIL retry_data: got %h expected 12345678", dload);
    end
  endtask

  task automatic test_drop();
    int bad; bit hok, dok;
    run_txn(OP_LOAD, 32'h3C0, 32'h0, 32'hA5A50F0F, 2, -1, 1'b1, 1'b0, 32'h0, bad, hok, dok);
    n_cmp++;
    if (bad !== 0 || !hok || !dok) begin
      n_bad++; $display("FAIL drop_req: got bad=%0d hit_ok=%b data_ok=%b expected 0/1/1", bad, hok, dok);
    end
  endtask

  task automatic test_random();
    int bad, nb, ep; bit hok, dok; memop_t op;
    for (int t = 0; t < 24; t++) begin
      op = memop_t'($urandom_range(0, 2));
      nb = $urandom_range(0, 4);
      ep = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb)) : -1;
      run_txn(op, $urandom, $urandom, $urandom, nb, ep, 1'($urandom_range(0, 1)),
              1'b0, 32'h0, bad, hok, dok);
      n_cmp++;
      if (bad !== 0 || !hok || !dok) begin
        n_bad++;
        $display("FAIL random_%0d: got bad=%0d hit_ok=%b data_ok=%b expected 0/1/1", t, bad, hok, dok);
      end
    end
  endtask

  task automatic test_watchdog();
    int bad; bit hok, dok;
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h300; ramstate = FREE;
    for (int c = 1; c <= 300; c++) begin
      @(negedge CLK);
      if (c == 250) begin
        n_cmp++;
        if (memerr !== 1'b0) begin n_bad++; $display("FAIL wd_early: got %b expected 0", memerr); end
      end
      if (c == 260) begin
        n_cmp++;
        if (memerr !== 1'b1) begin n_bad++; $display("FAIL wd_set: got %b expected 1", memerr); end
      end
      ramstate = BUSY;
    end
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'h0BADF00D;
    @(negedge CLK);
    n_cmp++;
    if (dhit !== 1'b1 || dload !== 32'h0BADF00D || memerr !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_hit: got dhit=%b dload=%h memerr=%b expected 1/0badf00d/1", dhit, dload, memerr);
    end
    m_dload = 32'h0BADF00D; m_memerr = 1'b1;
    dREN = 1'b0; ramstate = FREE;
    run_txn(OP_FETCH, 32'h80, 32'h0, $urandom, 1, -1, 1'b0, 1'b0, 32'h0, bad, hok, dok);
    n_cmp++;
    if (bad !== 0 || !hok || memerr !== 1'b1) begin
      n_bad++; $display("FAIL wd_sticky: got bad=%0d memerr=%b expected 0/1", bad, memerr);
    end
  endtask

  task automatic test_reset_mid();
    int bad; bit hok, dok;
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h7F0; ramstate = FREE;
    @(negedge CLK); ramstate = BUSY;
    @(negedge CLK); ramstate = BUSY;
    #1 nRST = 1'b0;
    #1;
    n_cmp++;
    if ({ihit, dhit, ramREN, ramWEN, memerr} !== 5'b0 || ramaddr !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid_async: got flags=%b addr=%h expected 00000/0",
               {ihit, dhit, ramREN, ramWEN, memerr}, ramaddr);
    end
    m_memerr = 1'b0; m_dload = '0; m_iload = '0;
    ramstate = ACCESS;
    repeat (2) begin
      @(negedge CLK);
      n_cmp++;
      if (dhit !== 1'b0 || ramREN !== 1'b0) begin
        n_bad++; $display("FAIL rst_mid_nohit: got dhit=%b ramREN=%b expected 0/0", dhit, ramREN);
      end
    end
    dREN = 1'b0; ramstate = FREE;
    nRST = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (dhit !== 1'b0 || ramREN !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_release: got dhit=%b ramREN=%b expected 0/0", dhit, ramREN);
    end
    run_txn(OP_LOAD, 32'h7F4, 32'h0, 32'hCAFE1234, 1, -1, 1'b0, 1'b0, 32'h0, bad, hok, dok);
    n_cmp++;
    if (bad !== 0 || !hok || !dok) begin
      n_bad++; $display("FAIL rst_mid_fresh: got bad=%0d hit_ok=%b data_ok=%b expected 0/1/1", bad, hok, dok);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_retry();
    test_drop();
    test_random();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_control.md
# memory_control

Responder end of the CPU's memory request protocol. Accepts instruction fetch (`iREN`) and data load/store (`dREN`/`dWEN`) requests from the request unit side of the datapath, arbitrates them onto a single-ported RAM with variable latency, and returns one-cycle `ihit`/`dhit` pulses with registered load data. It sits between the CPU datapath and the RAM model, and is the only block that drives RAM control.

## Interface
Parameters:
- `MAX_WAIT`, default 255: RAM wait cycles tolerated per transaction before `memerr` is raised.

Ports:
- `CLK`  in  1  system clock, single clock domain, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `iREN`  in  1  instruction fetch request; level, held until `ihit`.
- `iaddr`  in  32  fetch address (`word_t`).
- `dREN`  in  1  data load request; level, held until `dhit`.
- `dWEN`  in  1  data store request; level, held until `dhit`. `dREN && dWEN` is illegal.
- `daddr`  in  32  data address.
- `dstore`  in  32  store data.
- `ihit`  out  1  one-cycle fetch completion pulse.
- `iload`  out  32  fetched word; valid while `ihit` is high.
- `dhit`  out  1  one-cycle data completion pulse.
- `dload`  out  32  loaded word; valid while `dhit` is high after a load.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data, valid when `ramstate == ACCESS`.
- `ramstate`  in  2  `ramstate_t`: FREE, BUSY, ACCESS, ERROR.
- `memerr`  out  1  sticky watchdog error flag.

## Operation
- States: IDLE, DATA, INSTR, RETRY, RESP.
- IDLE:
  - If `dREN | dWEN`: latch `daddr`, `dstore` and the op type, then go to DATA.
  - Else if `iREN`: latch `iaddr` and go to INSTR.
  - Data always has priority over instruction when both are asserted in the same cycle.
- DATA / INSTR:
  - Drive `ramREN` or `ramWEN`, `ramaddr` and `ramstore` from the latched values only.
  - On `ramstate == ACCESS`: capture `ramload` (loads and fetches) and go to RESP.
  - On `ramstate == ERROR`: go to RETRY.
  - On BUSY or FREE: stay.
- RETRY:
  - RAM enables are 0 for exactly one cycle.
  - Return to the saved DATA or INSTR state and reissue the identical request.
- RESP:
  - Assert exactly one of `ihit` or `dhit` for one cycle, with `iload` or `dload` holding the captured word.
  - RAM enables are 0.
  - Next state is IDLE. The requester must deassert its request on the edge that samples the hit.
- Once latched, a transaction always completes and returns its hit, even if the request input drops mid-transaction. Input address/data changes after the latch are ignored.
- Watchdog counter:
  - Cleared on entering DATA or INSTR; counts cycles spent in DATA or INSTR.
  - Saturates at `MAX_WAIT`; reaching `MAX_WAIT` sets `memerr`.
  - `memerr` clears only on reset. The FSM keeps waiting.
- Store hits leave `dload` unchanged.

## Timing
- Reset (asynchronous, immediate): state IDLE; `ihit`, `dhit`, `ramREN`, `ramWEN`, `memerr` = 0; `iload`, `dload`, `ramaddr`, `ramstore`, latches and counter = 0.
- All outputs are decoded from registered state and latches. There is no combinational path from request inputs to RAM outputs or hits.
- Latency for a request first seen in IDLE in cycle 0:
  - RAM driven from cycle 1.
  - If ACCESS arrives in cycle 1+N, the hit is in cycle 2+N.
  - Minimum is 2 cycles (N=0).
- Back-to-back requests: the cycle after RESP is IDLE, so the next request is accepted in that cycle.
- A queued `iREN` waiting behind a data transaction is serviced starting the IDLE cycle after that data transaction's RESP.
- Reset asserted mid-transaction: the request is abandoned, no hit is issued, and RAM enables drop asynchronously.

## Structure
- `cpu_types_pkg` already holds `word_t` and `ramstate_t`.
- Add `memctl_state_t` (IDLE, DATA, INSTR, RETRY, RESP) and the op-type enum to `cpu_types_pkg`.
- Ports are grouped in a new `memory_control_if` with `mc` and `tb` modports, matching the request-unit interface style.
- One natural sub-module, `mem_wait_counter`: the saturating watchdog, parameterised by `MAX_WAIT`.

## Test plan
- Fetch: `iREN=1`, `iaddr=0x40`, RAM BUSY for 2 cycles then ACCESS with `ramload=0x8C220004` -> `ramREN=1`, `ramaddr=0x40` for 3 cycles; `ihit=1` for one cycle with `iload=0x8C220004`.
- Simultaneous `iREN` (`iaddr=0x44`) and `dWEN` (`daddr=0x100`, `dstore=0xDEADBEEF`) -> `ramWEN` at 0x100 with 0xDEADBEEF and a `dhit` first; then `ramREN` at 0x44 and `ihit`; never both hits together.
- Load receiving ERROR once, then ACCESS with `ramload=0x12345678` -> enables 0 for one cycle, reissue at the same address, `dhit` with `dload=0x12345678`.
- `ramstate` held BUSY for 300 cycles with `MAX_WAIT=255` -> `memerr` rises after 255 wait cycles and stays high after a later ACCESS and hit, until `nRST`.
- `nRST` pulsed low during DATA wait -> all outputs 0 immediately, no `dhit`; after release a fresh `dREN` completes normally.
- `dREN` dropped and `daddr` changed one cycle after acceptance -> RAM still sees the original address and `dhit` still pulses.
